// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising little-endian word/half/byte accesses. Define MEMCTRL_IO_STALL_EN to hold off I/O stores while io_buffer_full.
module mem_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [1:0]  IO_BASE = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic              io_buffer_full,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic       io_store, io_block, mem_go, done_prev;
  logic [2:0] mem_n, next_k;
  logic [1:0] cap_idx;
  logic [31:0] rd_word;

  assign io_store = mem_we && (mem_addr[17:16] == IO_BASE);
`ifdef MEMCTRL_IO_STALL_EN
  assign io_block = io_store & io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_store & io_buffer_full;
  assign io_block  = 1'b0;
`endif

  assign mem_go    = mem_req & ~io_block;
  // The cycle carrying a done pulse never accepts, so a requester has one cycle to drop req.
  assign done_prev = if_done_q | mem_done_q;
  assign next_k    = cnt_q + 3'd1;
  assign cap_idx   = cnt_q[1:0] - 2'd1;

  always_comb begin
    case (mem_len)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  // Byte arriving this cycle belongs to the address driven last cycle (index k-1).
  always_comb begin
    rd_word = buf_q;
    rd_word[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    // NOTE: every _d is given its default first, so no path through this block can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    owner_mem_d = owner_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = '0;
    ram_wr_d    = 1'b0;
    ram_dout_d  = '0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!done_prev && (mem_go || if_req)) begin
          owner_mem_d = mem_go;
          addr_d      = mem_go ? mem_addr : if_addr;
          wdata_d     = mem_go ? mem_wdata : '0;
          nbytes_d    = mem_go ? mem_n : 3'd4;
          cnt_d       = '0;
          buf_d       = '0;
          ram_a_d     = mem_go ? mem_addr : if_addr;
          if (mem_go && mem_we) begin
            state_d    = WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = RD;
          end
        end
      end

      RD: begin
        if (cnt_q != 3'd0) buf_d = rd_word;
        if (cnt_q == nbytes_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (owner_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rd_word;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = rd_word;
          end
        end else begin
          cnt_d = next_k;
          if (next_k < nbytes_q) ram_a_d = addr_q + ADDR_W'(next_k);
        end
      end

      WR: begin
        if (next_k < nbytes_q) begin
          cnt_d      = next_k;
          ram_wr_d   = 1'b1;
          ram_a_d    = addr_q + ADDR_W'(next_k);
          ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
        end else begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      owner_mem_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      owner_mem_q <= owner_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign busy      = (state_q != IDLE);

endmodule
